timer_ctrl: RTL and testbench

Sequencing controller for the countdown timer datapath. It turns four debounced push-button levels into a set/arm/run/pause/alarm state machine, holds the hr/min/sec preset being edited, and issues the load pulse and run enable that drive the timer. It also detects expiry from the timer's remaining-time bus and produces a bounded alarm output. It sits between the board button debouncers and the countdown timer instance.

---
 rtl/timer_pkg.sv | 38 +++
 rtl/btn_edge.sv | 25 ++
 rtl/timer_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown-timer control slice.
// Field widths match the timer's packed remaining-time bus {hr, min, sec, ms}.
package timer_pkg;

  localparam int HR_W   = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MS_W   = 10;
  localparam int TIME_W = 27;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [2:0] {
    IDLE,
    SET_HR,
    SET_MIN,
    SET_SEC,
    ARMED,
    RUN,
    PAUSE,
    ALARM
  } state_e;

  localparam logic [1:0] EDIT_NONE = 2'd0;
  localparam logic [1:0] EDIT_HR   = 2'd1;
  localparam logic [1:0] EDIT_MIN  = 2'd2;
  localparam logic [1:0] EDIT_SEC  = 2'd3;

  // One wrapping step of an edit field in the range 0..max_val.
  function automatic logic [5:0] step_field(input logic [5:0] val,
                                            input logic [5:0] max_val,
                                            input logic       up);
    if (up) return (val >= max_val) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max_val : val - 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button level.
// The first clock after reset only primes the history, so a held button never counts as a press.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev_q;
  logic primed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      prev_q   <= level;
      primed_q <= 1'b1;
      press    <= level & ~prev_q & primed_q;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Button-driven sequencer for the countdown timer: preset editing, arm/run/pause,
// expiry detection and a bounded alarm. The FSM state is kept in the 'state' signal.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_CYCLES = 5000,
  parameter int HR_MAX       = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_start,
  input  logic [TIME_W-1:0] remaining,
  output logic [HR_W-1:0]   preset_hr,
  output logic [MIN_W-1:0]  preset_min,
  output logic [SEC_W-1:0]  preset_sec,
  output logic [MS_W-1:0]   preset_ms,
  output logic              load,
  output logic              run,
  output logic              alarm,
  output logic [1:0]        edit_sel
);

  localparam int CNT_W = $clog2(ALARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(ALARM_CYCLES);

  state_e           state, state_d;
  logic             load_d;
  logic [CNT_W-1:0] alarm_cnt;

  logic p_mode, p_up, p_down, p_start;
  logic sel_start, sel_mode, sel_up, sel_down, any_press;
  logic preset_zero;

  btn_edge u_edge_mode  (.clk(clk), .reset(reset), .level(btn_mode),  .press(p_mode));
  btn_edge u_edge_up    (.clk(clk), .reset(reset), .level(btn_up),    .press(p_up));
  btn_edge u_edge_down  (.clk(clk), .reset(reset), .level(btn_down),  .press(p_down));
  btn_edge u_edge_start (.clk(clk), .reset(reset), .level(btn_start), .press(p_start));

  // Only one press survives per cycle: start > mode > up > down.
  assign sel_start = p_start;
  assign sel_mode  = p_mode & ~p_start;
  assign sel_up    = p_up & ~p_start & ~p_mode;
  assign sel_down  = p_down & ~p_start & ~p_mode & ~p_up;
  assign any_press = p_start | p_mode | p_up | p_down;

  assign preset_zero = (preset_hr == '0) && (preset_min == '0) && (preset_sec == '0);

  always_comb begin
    state_d = state;
    load_d  = 1'b0;
    case (state)
      IDLE:    if (sel_mode) state_d = SET_HR;
      SET_HR:  if (sel_mode) state_d = SET_MIN;
      SET_MIN: if (sel_mode) state_d = SET_SEC;
      SET_SEC: begin
        if (sel_mode) begin
          state_d = ARMED;
          load_d  = 1'b1;
        end
      end
      ARMED: begin
        if (sel_start) begin
          if (!preset_zero) state_d = RUN;
        end else if (sel_mode) begin
          state_d = SET_HR;
        end
      end
      // Expiry outranks a same-cycle start.
      RUN: begin
        if (remaining == '0)  state_d = ALARM;
        else if (sel_start)   state_d = PAUSE;
      end
      PAUSE: begin
        if (sel_start)        state_d = RUN;
        else if (sel_mode)    state_d = SET_HR;
      end
      ALARM:   if (any_press || alarm_cnt >= CNT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edit_sel = EDIT_NONE;
    case (state)
      SET_HR:  edit_sel = EDIT_HR;
      SET_MIN: edit_sel = EDIT_MIN;
      SET_SEC: edit_sel = EDIT_SEC;
      default: edit_sel = EDIT_NONE;
    endcase
  end

  assign run       = (state == RUN);
  assign alarm     = (state == ALARM);
  assign preset_ms = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      load       <= 1'b0;
      alarm_cnt  <= '0;
      preset_hr  <= '0;
      preset_min <= '0;
      preset_sec <= '0;
    end else begin
      state <= state_d;
      load  <= load_d;
      // Held at zero outside ALARM, so every ALARM visit starts counting from 0.
      if (state != ALARM)          alarm_cnt <= '0;
      else if (alarm_cnt != CNT_SAT) alarm_cnt <= alarm_cnt + CNT_W'(1);
      if (sel_up || sel_down) begin
        case (state)
          SET_HR:  preset_hr  <= HR_W'(step_field({1'b0, preset_hr}, 6'(HR_MAX), sel_up));
          SET_MIN: preset_min <= step_field(preset_min, 6'(MIN_MAX), sel_up);
          SET_SEC: preset_sec <= step_field(preset_sec, 6'(SEC_MAX), sel_up);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: scenario tasks plus randomized button presses checked against
// a press-level behavioural model of the controller.
module tb_timer_ctrl;

  localparam int ALARM_N = 8;
  localparam int HR_MAX  = 23;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic [26:0] remaining = 27'd1000;
  logic [4:0]  preset_hr;
  logic [5:0]  preset_min, preset_sec;
  logic [9:0]  preset_ms;
  logic        load, run, alarm;
  logic [1:0]  edit_sel;
  logic [21:0] obs;

  int tests = 0;
  int fails = 0;

  // Model: state by name, preset fields {hr, min, sec}, pending load flag.
  string m_st;
  int    m_f[3];
  int    m_max[3];
  bit    m_load;

  timer_ctrl #(.ALARM_CYCLES(ALARM_N), .HR_MAX(HR_MAX)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .remaining(remaining),
    .preset_hr(preset_hr), .preset_min(preset_min), .preset_sec(preset_sec),
    .preset_ms(preset_ms), .load(load), .run(run), .alarm(alarm), .edit_sel(edit_sel)
  );

  always #5 clk = ~clk;

  assign obs = {edit_sel, run, alarm, load, preset_hr, preset_min, preset_sec};

  function automatic void model_reset();
    m_st = "IDLE";
    m_f = '{0, 0, 0};
    m_max = '{HR_MAX, 59, 59};
    m_load = 1'b0;
  endfunction

  function automatic void model_press(input bit s, input bit m, input bit u, input bit d);
    int idx;
    m_load = 1'b0;
    if (m_st == "ALARM") begin
      if (s | m | u | d) m_st = "IDLE";
      return;
    end
    if (s) begin
      if (m_st == "ARMED" && (m_f[0] + m_f[1] + m_f[2]) != 0) m_st = "RUN";
      else if (m_st == "RUN")   m_st = "PAUSE";
      else if (m_st == "PAUSE") m_st = "RUN";
    end else if (m) begin
      case (m_st)
        "IDLE", "ARMED", "PAUSE": m_st = "SET_HR";
        "SET_HR":  m_st = "SET_MIN";
        "SET_MIN": m_st = "SET_SEC";
        "SET_SEC": begin m_st = "ARMED"; m_load = 1'b1; end
        default: ;
      endcase
    end else if (u | d) begin
      idx = (m_st == "SET_HR") ? 0 : (m_st == "SET_MIN") ? 1 : (m_st == "SET_SEC") ? 2 : -1;
      if (idx >= 0) m_f[idx] = (m_f[idx] + (u ? 1 : m_max[idx])) % (m_max[idx] + 1);
    end
  endfunction

  function automatic logic [21:0] model_vec();
    logic [1:0] s;
    s = (m_st == "SET_HR") ? 2'd1 : (m_st == "SET_MIN") ? 2'd2 : (m_st == "SET_SEC") ? 2'd3 : 2'd0;
    return {s, 1'(m_st == "RUN"), 1'(m_st == "ALARM"), 1'(m_load),
            5'(m_f[0]), 6'(m_f[1]), 6'(m_f[2])};
  endfunction

  task automatic set_btns(input bit s, input bit m, input bit u, input bit d);
    btn_start = s; btn_mode = m; btn_up = u; btn_down = d;
  endtask

  // One-cycle button pulse; returns two negedges later when the effect is visible.
  task automatic do_press(input bit s, input bit m, input bit u, input bit d);
    set_btns(s, m, u, d);
    @(negedge clk);
    set_btns(0, 0, 0, 0);
    @(negedge clk);
    model_press(s, m, u, d);
  endtask

  task automatic do_reset();
    set_btns(0, 0, 0, 0);
    remaining = 27'd1000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  // From IDLE: preset 0:00:01, then ARMED.
  task automatic arm_one_sec();
    do_press(0, 1, 0, 0); do_press(0, 1, 0, 0); do_press(0, 1, 0, 0);
    do_press(0, 0, 1, 0); do_press(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (obs !== 22'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", obs); end
    tests++;
    if (preset_ms !== 10'd0) begin fails++; $display("FAIL reset_ms: got %0d want 0", preset_ms); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    tests++;
    if (obs !== 22'd0) begin fails++; $display("FAIL post_reset_idle: got %h want 0", obs); end
  endtask

  task automatic test_preset_arm();
    logic [3:0] seq[13];
    seq = '{4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0100,
            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_press(seq[i][3], seq[i][2], seq[i][1], seq[i][0]);
      tests++;
      if (obs !== model_vec()) begin
        fails++; $display("FAIL preset_arm[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
    tests++;
    if ({load, edit_sel} !== 3'b100) begin
      fails++; $display("FAIL arm_load_first: got load=%b sel=%0d want load=1 sel=0", load, edit_sel);
    end
    @(negedge clk);
    tests++;
    if (load !== 1'b0) begin fails++; $display("FAIL arm_load_width: got %b want 0", load); end
    tests++;
    if ({preset_hr, preset_min, preset_sec} !== {5'd2, 6'd59, 6'd5}) begin
      fails++; $display("FAIL arm_preset: got %0d:%0d:%0d want 2:59:5", preset_hr, preset_min, preset_sec);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_press(0, 1, 0, 0);
    do_press(0, 0, 0, 1);
    tests++;
    if (preset_hr !== 5'd23) begin fails++; $display("FAIL wrap_hr_down: got %0d want 23", preset_hr); end
    do_press(0, 0, 1, 0);
    tests++;
    if (preset_hr !== 5'd0) begin fails++; $display("FAIL wrap_hr_up: got %0d want 0", preset_hr); end
    do_press(0, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      do_press(0, 0, 1, 0);
      if (i == 58) begin
        tests++;
        if (preset_min !== 6'd59) begin fails++; $display("FAIL wrap_min_59: got %0d want 59", preset_min); end
      end
    end
    tests++;
    if (obs !== model_vec() || preset_min !== 6'd0) begin
      fails++; $display("FAIL wrap_min_60: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_run_pause();
    do_reset();
    arm_one_sec();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    tests++;
    if (run !== 1'b0) begin fails++; $display("FAIL run_latency_early: got %b want 0", run); end
    @(negedge clk);
    model_press(1, 0, 0, 0);
    tests++;
    if (run !== 1'b1) begin fails++; $display("FAIL run_latency: got %b want 1", run); end
    do_press(1, 0, 0, 0);
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL pause: got %h want %h", obs, model_vec()); end
    do_press(1, 0, 0, 0);
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL resume: got %h want %h", obs, model_vec()); end
    btn_start = 1'b1;
    repeat (100) @(negedge clk);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
    model_press(1, 0, 0, 0);
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL hold_start: got %h want %h", obs, model_vec()); end
  endtask

  task automatic test_expiry();
    int n;
    do_reset();
    arm_one_sec();
    do_press(1, 0, 0, 0);
    remaining = 27'd0;
    @(negedge clk);
    remaining = 27'd500;
    tests++;
    if ({run, alarm} !== 2'b01) begin fails++; $display("FAIL expiry: got run=%b alarm=%b want 0/1", run, alarm); end
    n = 0;
    for (int g = 0; g < 40 && alarm === 1'b1; g++) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != ALARM_N) begin fails++; $display("FAIL alarm_len: got %0d want %0d", n, ALARM_N); end
    m_st = "IDLE";
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL alarm_timeout: got %h want %h", obs, model_vec()); end
    do_press(0, 1, 0, 0);
    tests++;
    if (edit_sel !== 2'd1) begin fails++; $display("FAIL idle_after_alarm: got %0d want 1", edit_sel); end
    do_press(0, 1, 0, 0); do_press(0, 1, 0, 0); do_press(0, 1, 0, 0);
    do_press(1, 0, 0, 0);
    remaining = 27'd0;
    @(negedge clk);
    remaining = 27'd500;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    tests++;
    if (alarm !== 1'b1) begin fails++; $display("FAIL clear_early: got %b want 1", alarm); end
    @(negedge clk);
    tests++;
    if ({alarm, run, edit_sel} !== 4'b0000) begin
      fails++; $display("FAIL alarm_clear: got alarm=%b run=%b sel=%0d want 0/0/0", alarm, run, edit_sel);
    end
  endtask

  task automatic test_edge_cases();
    do_reset();
    repeat (4) do_press(0, 1, 0, 0);
    do_press(1, 0, 0, 0);
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL zero_start: got %h want %h", obs, model_vec()); end
    do_press(0, 1, 0, 0);
    do_press(0, 0, 1, 0);
    repeat (3) do_press(0, 1, 0, 0);
    do_press(1, 1, 0, 0);
    tests++;
    if (obs !== model_vec() || run !== 1'b1) begin
      fails++; $display("FAIL start_mode_same: got %h want %h", obs, model_vec());
    end
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    remaining = 27'd0;
    @(negedge clk);
    remaining = 27'd500;
    tests++;
    if ({run, alarm} !== 2'b01) begin fails++; $display("FAIL expiry_vs_start: got run=%b alarm=%b want 0/1", run, alarm); end
    repeat (12) @(negedge clk);
    m_st = "IDLE";
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL edge_timeout: got %h want %h", obs, model_vec()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    arm_one_sec();
    do_press(1, 0, 0, 0);
    btn_mode = 1'b1;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({run, alarm, load} !== 3'b000) begin
      fails++; $display("FAIL async_reset_ctrl: got run=%b alarm=%b load=%b want 0", run, alarm, load);
    end
    tests++;
    if (obs !== 22'd0) begin fails++; $display("FAIL async_reset_all: got %h want 0", obs); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (edit_sel !== 2'd0) begin fails++; $display("FAIL held_through_reset: got %0d want 0", edit_sel); end
    btn_mode = 1'b0;
    @(negedge clk);
    model_reset();
    do_press(0, 1, 0, 0);
    tests++;
    if (obs !== model_vec()) begin fails++; $display("FAIL press_after_reset: got %h want %h", obs, model_vec()); end
  endtask

  task automatic test_random();
    bit s, m, u, d;
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      remaining = 27'($urandom_range(1, 100000));
      r = $urandom_range(0, 15);
      s = (r == 0) || (r == 15);
      m = (r >= 1 && r <= 4) || (r == 15);
      u = (r >= 5 && r <= 9) || (r == 14);
      d = (r >= 10 && r <= 14);
      do_press(s, m, u, d);
      tests++;
      if (obs !== model_vec()) begin
        fails++; $display("FAIL rand_press[%0d]: got %h want %h", i, obs, model_vec());
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      m_load = 1'b0;
      tests++;
      if (obs !== model_vec()) begin
        fails++; $display("FAIL rand_idle[%0d]: got %h want %h", i, obs, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_preset_arm();
    test_wrap();
    test_run_pause();
    test_expiry();
    test_edge_cases();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
